raid_ecc_responder: RTL and testbench

- Storage-side responder to the host command controller: accepts one-cycle write/read/rebuild requests and answers with one-cycle done pulses.
- Holds a 3-disk array: disk0 = data[7:0], disk1 = data[15:8], disk2 = XOR parity. Each disk byte is stored as a Hamming(12,8) SEC codeword.
- Reads correct single-bit errors per disk and reconstruct an uncorrectable disk from the other two.
- On a disk-failure request it rebuilds the whole array from the surviving disks.

---
 rtl/raid_ecc_pkg.sv | 49 ++++
 rtl/hamming_12_8_dec.sv | 34 +++
 rtl/raid_ecc_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_raid_ecc_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raid_ecc_pkg.sv
// Shared types, constants and Hamming(12,8) helpers for the RAID ECC responder.
// Codeword bit k holds Hamming position k+1; parity lives at positions 1, 2, 4, 8.
package raid_ecc_pkg;

    localparam int         CW_W    = 12;
    localparam logic [2:0] DISK_OK = 3'b111;

    // Codeword bit index of data bit j, packed 4 bits per entry (d7 in the top nibble).
    // d0..d7 sit at positions 3,5,6,7,9,10,11,12 -> bits 2,4,5,6,8,9,10,11.
    localparam logic [31:0] DATA_BITS = {4'd11, 4'd10, 4'd9, 4'd8,
                                         4'd6,  4'd5,  4'd4, 4'd2};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_COMMIT = 3'd1,
        ST_RD_FETCH  = 3'd2,
        ST_RD_DECODE = 3'd3,
        ST_RB_READ   = 3'd4,
        ST_RB_WRITE  = 3'd5,
        ST_RB_FAIL   = 3'd6
    } state_t;

    // XOR of the positions of all set bits; zero for a clean codeword.
    function automatic logic [3:0] hamming_syn(input logic [CW_W-1:0] cw);
        logic [3:0] syn;
        syn = 4'd0;
        for (int k = 0; k < CW_W; k++) begin
            syn = syn ^ (cw[k] ? 4'(k + 1) : 4'd0);
        end
        return syn;
    endfunction

    // Place the data bits, then set each parity bit to cancel its syndrome bit.
    function automatic logic [CW_W-1:0] hamming_enc(input logic [7:0] d);
        logic [CW_W-1:0] cw;
        logic [3:0]      syn;
        cw = '0;
        for (int j = 0; j < 8; j++) begin
            cw[DATA_BITS[j*4 +: 4]] = d[j];
        end
        syn   = hamming_syn(cw);
        cw[0] = syn[0];
        cw[1] = syn[1];
        cw[3] = syn[2];
        cw[7] = syn[3];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_12_8_dec.sv
// Combinational Hamming(12,8) SEC decoder: corrects a single flipped bit and
// flags syndromes 13..15 (no such position) as an unusable codeword.
module hamming_12_8_dec
    import raid_ecc_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [7:0]      data,
    output logic            corrected,
    output logic            bad
);

    logic [3:0]      syn_s;
    logic [CW_W-1:0] fixed_s;

    // Syndrome check, single-bit repair and data extraction
    always_comb begin
        syn_s     = hamming_syn(cw);
        fixed_s   = cw;
        corrected = 1'b0;
        bad       = 1'b0;
        if (syn_s == 4'd0) begin
            corrected = 1'b0;
        end else if (syn_s <= 4'd12) begin
            fixed_s[syn_s - 4'd1] = ~cw[syn_s - 4'd1];
            corrected             = 1'b1;
        end else begin
            bad = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
            data[j] = fixed_s[DATA_BITS[j*4 +: 4]];
        end
    end

endmodule

// File: rtl/raid_ecc_responder.sv
// Storage-side responder: a 3-disk array (lo byte, hi byte, XOR parity), each
// entry stored as a Hamming(12,8) codeword. Serves writes, ECC-corrected reads
// with single-disk reconstruction, and full-array rebuild of one failed disk.
module raid_ecc_responder
    import raid_ecc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [15:0]       write_data,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_en,
    input  logic [2:0]        disk_stat,
    input  logic              inj_en,
    input  logic [1:0]        inj_disk,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [3:0]        inj_bit,
    output logic              wr_done,
    output logic              rd_done,
    output logic [15:0]       read_data,
    output logic [2:0]        ecc_corr,
    output logic              ecc_uncorr,
    output logic              raid_done,
    output logic              raid_fail,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // Disk storage; contents are not reset.
    logic [CW_W-1:0] disk_mem [3][DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        fail_disk_q, fail_disk_d;
    logic [CW_W-1:0]   cw_q [3];
    logic [CW_W-1:0]   cw_d [3];
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic              raid_done_q, raid_done_d;
    logic              raid_fail_q, raid_fail_d;
    logic [15:0]       read_data_q, read_data_d;
    logic [2:0]        ecc_corr_q, ecc_corr_d;
    logic              ecc_uncorr_q, ecc_uncorr_d;
    logic              busy_q, busy_d;

    logic [7:0]        dec_data_s [3];
    logic [2:0]        dec_corr_s;
    logic [2:0]        dec_bad_s;
    logic [15:0]       rd_bytes_s;
    logic              rd_unc_s;
    logic [7:0]        rb_lo_s, rb_hi_s;
    logic              mem_we_s;
    logic [7:0]        mem_lo_s, mem_hi_s;
    logic [CW_W-1:0]   mem_cw_s [3];
    logic [2:0]        inj_hit_s;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dec
            hamming_12_8_dec u_dec (
                .cw        (cw_q[gi]),
                .data      (dec_data_s[gi]),
                .corrected (dec_corr_s[gi]),
                .bad       (dec_bad_s[gi])
            );
        end
    endgenerate

    // Byte recovery: read path rebuilds one bad data disk, rebuild path recomputes the failed disk
    always_comb begin
        rd_bytes_s = {dec_data_s[1], dec_data_s[0]};
        rd_unc_s   = 1'b0;
        case (dec_bad_s)
            3'b000, 3'b100: rd_unc_s = 1'b0;
            3'b001:         rd_bytes_s[7:0]  = dec_data_s[1] ^ dec_data_s[2];
            3'b010:         rd_bytes_s[15:8] = dec_data_s[0] ^ dec_data_s[2];
            default:        rd_unc_s = 1'b1;
        endcase
        case (fail_disk_q)
            2'd0: begin
                rb_lo_s = dec_data_s[1] ^ dec_data_s[2];
                rb_hi_s = dec_data_s[1];
            end
            2'd1: begin
                rb_lo_s = dec_data_s[0];
                rb_hi_s = dec_data_s[0] ^ dec_data_s[2];
            end
            default: begin
                rb_lo_s = dec_data_s[0];
                rb_hi_s = dec_data_s[1];
            end
        endcase
    end

    // Request arbitration, FSM sequencing and output/next-register computation
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fail_disk_d  = fail_disk_q;
        wr_done_d    = 1'b0;
        rd_done_d    = 1'b0;
        raid_done_d  = 1'b0;
        raid_fail_d  = 1'b0;
        read_data_d  = read_data_q;
        ecc_corr_d   = ecc_corr_q;
        ecc_uncorr_d = ecc_uncorr_q;
        mem_we_s     = 1'b0;
        mem_lo_s     = wdata_q[7:0];
        mem_hi_s     = wdata_q[15:8];
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    state_d = ST_WR_COMMIT;
                end else if (rd_en) begin
                    addr_d  = address;
                    state_d = ST_RD_FETCH;
                end else if (disk_stat != DISK_OK) begin
                    addr_d = '0;
                    case (disk_stat)
                        3'b110: begin fail_disk_d = 2'd0; state_d = ST_RB_READ; end
                        3'b101: begin fail_disk_d = 2'd1; state_d = ST_RB_READ; end
                        3'b011: begin fail_disk_d = 2'd2; state_d = ST_RB_READ; end
                        default: state_d = ST_RB_FAIL;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_COMMIT: begin
                mem_we_s  = 1'b1;
                wr_done_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD_FETCH: begin
                state_d = ST_RD_DECODE;
            end
            ST_RD_DECODE: begin
                read_data_d  = rd_bytes_s;
                ecc_corr_d   = dec_corr_s;
                ecc_uncorr_d = rd_unc_s;
                rd_done_d    = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RB_READ: begin
                state_d = ST_RB_WRITE;
            end
            ST_RB_WRITE: begin
                mem_we_s = 1'b1;
                mem_lo_s = rb_lo_s;
                mem_hi_s = rb_hi_s;
                if (addr_q == {ADDR_W{1'b1}}) begin
                    raid_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_RB_READ;
                end
            end
            ST_RB_FAIL: begin
                raid_done_d = 1'b1;
                raid_fail_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign mem_cw_s[0] = hamming_enc(mem_lo_s);
    assign mem_cw_s[1] = hamming_enc(mem_hi_s);
    assign mem_cw_s[2] = hamming_enc(mem_lo_s ^ mem_hi_s);

    // Fetch register input: load all three disks in the fetch/read states, else hold
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if ((state_q == ST_RD_FETCH) || (state_q == ST_RB_READ)) begin
                cw_d[i] = disk_mem[i][addr_q];
            end else begin
                cw_d[i] = cw_q[i];
            end
        end
    end

    // Fault injection qualifier: valid target, and a same-entry write takes precedence
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            inj_hit_s[i] = inj_en && (inj_disk == 2'(i)) && (inj_bit <= 4'd11) &&
                           !(mem_we_s && (addr_q == inj_addr));
        end
    end

    // Disk memory write port and single-bit fault injection
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_we_s) begin
                disk_mem[i][addr_q] <= mem_cw_s[i];
            end
            if (inj_hit_s[i]) begin
                disk_mem[i][inj_addr][inj_bit] <= ~disk_mem[i][inj_addr][inj_bit];
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            fail_disk_q  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                cw_q[i] <= '0;
            end
            wr_done_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            raid_done_q  <= 1'b0;
            raid_fail_q  <= 1'b0;
            read_data_q  <= 16'h0000;
            ecc_corr_q   <= 3'b000;
            ecc_uncorr_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fail_disk_q  <= fail_disk_d;
            for (int i = 0; i < 3; i++) begin
                cw_q[i] <= cw_d[i];
            end
            wr_done_q    <= wr_done_d;
            rd_done_q    <= rd_done_d;
            raid_done_q  <= raid_done_d;
            raid_fail_q  <= raid_fail_d;
            read_data_q  <= read_data_d;
            ecc_corr_q   <= ecc_corr_d;
            ecc_uncorr_q <= ecc_uncorr_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_done    = wr_done_q;
    assign rd_done    = rd_done_q;
    assign read_data  = read_data_q;
    assign ecc_corr   = ecc_corr_q;
    assign ecc_uncorr = ecc_uncorr_q;
    assign raid_done  = raid_done_q;
    assign raid_fail  = raid_fail_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_raid_ecc_responder.sv
// Directed bench for raid_ecc_responder: a vector table of write/inject/read
// operations with hand-computed results, plus sequences for rebuild, refused
// rebuild, arbitration, injection/write collision and reset mid-rebuild.
module tb_raid_ecc_responder;

    localparam int ADDR_W = 8;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_INJ = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  disk;
        logic [3:0]  bitn;
        logic [15:0] exp_data;
        logic [2:0]  exp_corr;
        logic        exp_unc;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en, rd_en, inj_en;
    logic [15:0]       write_data;
    logic [ADDR_W-1:0] address, inj_addr;
    logic [2:0]        disk_stat;
    logic [1:0]        inj_disk;
    logic [3:0]        inj_bit;
    logic              wr_done, rd_done, ecc_uncorr, raid_done, raid_fail, busy;
    logic [15:0]       read_data;
    logic [2:0]        ecc_corr;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];

    raid_ecc_responder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .write_data (write_data),
        .address    (address),
        .rd_en      (rd_en),
        .disk_stat  (disk_stat),
        .inj_en     (inj_en),
        .inj_disk   (inj_disk),
        .inj_addr   (inj_addr),
        .inj_bit    (inj_bit),
        .wr_done    (wr_done),
        .rd_done    (rd_done),
        .read_data  (read_data),
        .ecc_corr   (ecc_corr),
        .ecc_uncorr (ecc_uncorr),
        .raid_done  (raid_done),
        .raid_fail  (raid_fail),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Clears one-cycle requests each cycle; returns cycle offset of the awaited
    // pulse (0 on timeout) and the number of unexpected done pulses seen.
    task automatic wait_pulse(input int sel, input int budget, input int rd_poke,
                              output int lat, output int stray);
        lat   = 0;
        stray = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0; disk_stat = 3'b111;
            if (c == rd_poke) begin
                rd_en   = 1'b1;
                address = 8'h10;
            end
            @(negedge clk);
            if (sel != 0 && wr_done)   stray++;
            if (sel != 1 && rd_done)   stray++;
            if (sel != 2 && raid_done) stray++;
            if ((sel == 0 && wr_done) || (sel == 1 && rd_done) || (sel == 2 && raid_done)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit chk);
        int lat, stray;
        @(posedge clk); #1;
        wr_en = 1'b1; address = a; write_data = d;
        wait_pulse(0, 10, 0, lat, stray);
        if (chk) check("wr_latency", lat, 2);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [15:0] d,
                           output logic [2:0] corr, output logic unc, output int lat);
        int stray;
        @(posedge clk); #1;
        rd_en = 1'b1; address = a;
        wait_pulse(1, 10, 0, lat, stray);
        d = read_data; corr = ecc_corr; unc = ecc_uncorr;
    endtask

    task automatic inject(input logic [1:0] dk, input logic [7:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        inj_en = 1'b1; inj_disk = dk; inj_addr = a; inj_bit = b;
        @(posedge clk); #1;
        inj_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] a,
                              input logic [15:0] ed, input logic [2:0] ec, input logic eu);
        logic [15:0] d; logic [2:0] c; logic u; int lat;
        do_read(a, d, c, u, lat);
        check({name, "_data"}, d, ed);
        check({name, "_flags"}, {c, u}, {ec, eu});
    endtask

    // Watch n cycles and count any done pulse
    task automatic watch_quiet(input int n, output int pulses);
        pulses = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (wr_done || rd_done || raid_done) pulses++;
        end
    endtask

    initial begin
        logic [15:0] d; logic [2:0] c; logic u;
        int lat, stray, q;

        vecs.push_back('{K_WR,  8'h10, 16'hA55A, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h10, 16'h0000, 2'd0, 4'd0,  16'hA55A, 3'b000, 1'b0});
        vecs.push_back('{K_WR,  8'h20, 16'h1234, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h20, 16'h0000, 2'd1, 4'd6,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h20, 16'h0000, 2'd0, 4'd0,  16'h1234, 3'b010, 1'b0});
        vecs.push_back('{K_WR,  8'h30, 16'hBEEF, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h30, 16'h0000, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h30, 16'h0000, 2'd0, 4'd1,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h30, 16'h0000, 2'd0, 4'd0,  16'hBEEE, 3'b001, 1'b0});
        vecs.push_back('{K_WR,  8'h31, 16'hC0DE, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h31, 16'h0000, 2'd0, 4'd3,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h31, 16'h0000, 2'd0, 4'd8,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h31, 16'h0000, 2'd0, 4'd0,  16'hC0DE, 3'b000, 1'b0});
        vecs.push_back('{K_WR,  8'h40, 16'h5AA5, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h40, 16'h0000, 2'd0, 4'd3,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h40, 16'h0000, 2'd0, 4'd8,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h40, 16'h0000, 2'd1, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h40, 16'h0000, 2'd1, 4'd11, 16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h40, 16'h0000, 2'd0, 4'd0,  16'hDAB5, 3'b000, 1'b1});
        vecs.push_back('{K_INJ, 8'h10, 16'h0000, 2'd3, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h10, 16'h0000, 2'd0, 4'd12, 16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h10, 16'h0000, 2'd0, 4'd0,  16'hA55A, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h10, 16'h0000, 2'd2, 4'd5,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h10, 16'h0000, 2'd0, 4'd0,  16'hA55A, 3'b100, 1'b0});
        vecs.push_back('{K_WR,  8'h60, 16'h0F0F, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h60, 16'h0000, 2'd2, 4'd3,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h60, 16'h0000, 2'd2, 4'd8,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h60, 16'h0000, 2'd0, 4'd0,  16'h0F0F, 3'b000, 1'b0});
        vecs.push_back('{K_WR,  8'h61, 16'h8001, 2'd0, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h61, 16'h0000, 2'd1, 4'd0,  16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_INJ, 8'h61, 16'h0000, 2'd1, 4'd11, 16'h0000, 3'b000, 1'b0});
        vecs.push_back('{K_RD,  8'h61, 16'h0000, 2'd0, 4'd0,  16'h8001, 3'b000, 1'b0});

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
        write_data = 16'h0000; address = 8'h00; disk_stat = 3'b111;
        inj_disk = 2'd0; inj_addr = 8'h00; inj_bit = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {wr_done, rd_done, raid_done, raid_fail, ecc_uncorr, busy, ecc_corr, read_data}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven write / inject / read vectors
        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_WR:  do_write(vecs[i].addr, vecs[i].data, 1'b1);
                K_INJ: inject(vecs[i].disk, vecs[i].addr, vecs[i].bitn);
                default: begin
                    do_read(vecs[i].addr, d, c, u, lat);
                    check($sformatf("vec%0d_rd_latency", i), lat, 3);
                    check($sformatf("vec%0d_rd_data", i), d, vecs[i].exp_data);
                    check($sformatf("vec%0d_rd_flags", i), {c, u}, {vecs[i].exp_corr, vecs[i].exp_unc});
                end
            endcase
        end

        // Simultaneous write and read: only the write happens
        @(posedge clk); #1;
        wr_en = 1'b1; rd_en = 1'b1; address = 8'h50; write_data = 16'h6789;
        wait_pulse(0, 10, 0, lat, stray);
        check("wr_rd_collide_latency", lat, 2);
        watch_quiet(5, q);
        check("wr_rd_collide_no_rd", q + stray, 0);
        read_check("wr_rd_collide_read", 8'h50, 16'h6789, 3'b000, 1'b0);

        // Injection into the entry being committed loses to the write
        @(posedge clk); #1;
        wr_en = 1'b1; address = 8'h70; write_data = 16'h1111;
        @(posedge clk); #1;
        wr_en = 1'b0; inj_en = 1'b1; inj_disk = 2'd0; inj_addr = 8'h70; inj_bit = 4'd2;
        @(posedge clk); #1;
        inj_en = 1'b0;
        @(negedge clk);
        check("wr_vs_inj_done", wr_done, 1'b1);
        read_check("wr_vs_inj_read", 8'h70, 16'h1111, 3'b000, 1'b0);

        // Fill the array, damage disk2 everywhere plus one disk0 entry, rebuild disk2
        for (int a = 0; a < 256; a++) do_write(8'(a), {8'(a), 8'(a)}, 1'b0);
        for (int a = 0; a < 256; a++) inject(2'd2, 8'(a), 4'(a % 12));
        inject(2'd0, 8'h77, 4'd5);
        @(posedge clk); #1;
        disk_stat = 3'b011;
        wait_pulse(2, 600, 0, lat, stray);
        check("rb2_latency", lat, 513);
        check("rb2_fail", raid_fail, 1'b0);
        check("rb2_stray", stray, 0);
        for (int a = 0; a < 256; a++) begin
            do_read(8'(a), d, c, u, lat);
            check($sformatf("rb2_read_%02h", a), {c, u, d}, {3'b000, 1'b0, 8'(a), 8'(a)});
        end

        // Two failed disks: refused, memory untouched (disk2 error stays visible)
        inject(2'd2, 8'h05, 4'd7);
        @(posedge clk); #1;
        disk_stat = 3'b001;
        wait_pulse(2, 10, 0, lat, stray);
        check("rbfail_latency", lat, 2);
        check("rbfail_flag", raid_fail, 1'b1);
        read_check("rbfail_untouched", 8'h05, 16'h0505, 3'b100, 1'b0);

        // Disk0 rebuild with a stray read request mid-sweep
        inject(2'd0, 8'h22, 4'd3);
        inject(2'd0, 8'h22, 4'd8);
        inject(2'd1, 8'h22, 4'd2);
        read_check("pre_rb0", 8'h22, 16'h2222, 3'b010, 1'b0);
        @(posedge clk); #1;
        disk_stat = 3'b110;
        wait_pulse(2, 600, 40, lat, stray);
        check("rb0_latency", lat, 513);
        check("rb0_fail", raid_fail, 1'b0);
        check("rb0_rd_ignored", stray, 0);
        read_check("rb0_scrub22", 8'h22, 16'h2222, 3'b000, 1'b0);
        read_check("rb0_scrub05", 8'h05, 16'h0505, 3'b000, 1'b0);

        // Reset in the middle of a rebuild
        @(posedge clk); #1;
        disk_stat = 3'b011;
        @(posedge clk); #1;
        disk_stat = 3'b111;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("rb_busy", busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs",
              {wr_done, rd_done, raid_done, raid_fail, ecc_uncorr, busy, ecc_corr, read_data}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busy, 1'b0);
        read_check("post_reset_read", 8'h33, 16'h3333, 3'b000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
